uart_tx_engine: RTL and testbench

Transmit-side UART serializer that drains the peripheral's TX byte FIFO and drives the serial line. It pops one byte at a time from the FIFO's first-word-fall-through read port and frames it: start bit, data LSB-first, optional parity, then 1 or 2 stop bits. Bit period comes from a runtime baud divisor held in the UART control registers. Consecutive frames go out back-to-back while the FIFO stays non-empty.

---
 rtl/uart_tx_engine.sv | 171 +++++++++++++++++
 tb/tb_uart_tx_engine.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine.sv
// UART transmit serializer: pops bytes from a FWFT FIFO and frames them as
// start / data (LSB first) / optional parity / 1-2 stop bits at a runtime baud divisor.
module uart_tx_engine #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_BITS-1:0] fifo_data_i,
    input  logic                 fifo_empty_i,
    output logic                 fifo_rd_en_o,
    input  logic                 tx_en_i,
    input  logic [DIV_WIDTH-1:0] baud_div_i,
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    input  logic                 stop2_i,
    output logic                 tx_o,
    output logic                 busy_o,
    output logic                 tx_done_o
);

    localparam int unsigned BitCntW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [BitCntW-1:0]   bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_en_q, par_en_d;
    logic                 par_q, par_d;
    logic                 stop2_q, stop2_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 last_bit, last_stop, start_cond;

    assign last_bit   = (cnt_q == div_q - DIV_WIDTH'(1));
    assign last_stop  = (state_q == StStop) && last_bit && (!stop2_q || stop_idx_q);
    assign start_cond = !rst_i && tx_en_i && !fifo_empty_i &&
                        ((state_q == StIdle) || last_stop);

    assign fifo_rd_en_o = start_cond;
    assign tx_o         = tx_q;
    assign busy_o       = busy_q;
    assign tx_done_o    = done_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_d      = par_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;

        case (state_q)
            StIdle: ;
            StStart: begin
                if (last_bit) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
            StData: begin
                if (last_bit) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BitCntW'(DATA_BITS - 1)) begin
                        stop_idx_d = 1'b0;
                        state_d    = par_en_q ? StParity : StStop;
                    end else begin
                        bit_d = bit_q + BitCntW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
            StParity: begin
                if (last_bit) begin
                    cnt_d      = '0;
                    stop_idx_d = 1'b0;
                    state_d    = StStop;
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
            StStop: begin
                if (last_bit) begin
                    cnt_d = '0;
                    if (stop2_q && !stop_idx_q) begin
                        stop_idx_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q + DIV_WIDTH'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // A new frame overrides the end-of-frame transition to allow zero-gap frames.
        if (start_cond) begin
            state_d    = StStart;
            cnt_d      = '0;
            bit_d      = '0;
            stop_idx_d = 1'b0;
            shift_d    = fifo_data_i;
            div_d      = (baud_div_i == '0) ? DIV_WIDTH'(1) : baud_div_i;
            par_en_d   = parity_en_i;
            par_d      = (^fifo_data_i) ^ parity_odd_i;
            stop2_d    = stop2_i;
        end

        // Outputs are registered, so derive them from the state being entered.
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
        done_d = (state_d == StStop) && (cnt_d == div_d - DIV_WIDTH'(1)) &&
                 (!stop2_d || stop_idx_d);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_q      <= par_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: a per-cycle line model built from frame rules,
// plus literal expectations for the directed frames.
module tb_uart_tx_engine;

    logic        clk;
    logic        rst;
    logic [7:0]  fifo_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        tx_en;
    logic [15:0] baud_div;
    logic        parity_en;
    logic        parity_odd;
    logic        stop2;
    logic        tx;
    logic        busy;
    logic        tx_done;

    int   n_cmp = 0;
    int   n_err = 0;
    int   pop_cnt = 0;
    int   cyc = 0;
    int   pop_cyc[$];
    logic [7:0] fq[$];
    bit   exp_tx[$];
    bit   exp_done[$];
    bit   log_tx[$];
    bit   log_done[$];
    bit   exp_pop;

    uart_tx_engine #(
        .DATA_BITS(8),
        .DIV_WIDTH(16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .fifo_data_i (fifo_data),
        .fifo_empty_i(fifo_empty),
        .fifo_rd_en_o(fifo_rd_en),
        .tx_en_i     (tx_en),
        .baud_div_i  (baud_div),
        .parity_en_i (parity_en),
        .parity_odd_i(parity_odd),
        .stop2_i     (stop2),
        .tx_o        (tx),
        .busy_o      (busy),
        .tx_done_o   (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        fifo_empty = (fq.size() == 0);
        fifo_data  = (fq.size() == 0) ? 8'h00 : fq[0];
    endtask

    // Expected line for one frame, one entry per clock cycle.
    task automatic push_frame(input logic [7:0] b);
        int d;
        bit bits[$];
        d = (baud_div == 16'd0) ? 1 : int'(baud_div);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (parity_en) bits.push_back((^b) ^ parity_odd);
        bits.push_back(1'b1);
        if (stop2) bits.push_back(1'b1);
        foreach (bits[i]) begin
            for (int j = 0; j < d; j++) begin
                exp_tx.push_back(bits[i]);
                exp_done.push_back(1'b0);
            end
        end
        exp_done[exp_done.size()-1] = 1'b1;
    endtask

    // Model + compare: check at negedge, advance the model just after posedge.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_pop = 1'b0;
                check("rst_tx", tx, 1);
                check("rst_busy", busy, 0);
                check("rst_done", tx_done, 0);
                check("rst_rd_en", fifo_rd_en, 0);
            end else begin
                exp_pop = tx_en && (fq.size() > 0) && (exp_tx.size() <= 1);
                check("rd_en", fifo_rd_en, exp_pop);
                if (exp_tx.size() == 0) begin
                    check("idle_tx", tx, 1);
                    check("idle_busy", busy, 0);
                    check("idle_done", tx_done, 0);
                end else begin
                    check("line_tx", tx, exp_tx[0]);
                    check("line_busy", busy, 1);
                    check("line_done", tx_done, exp_done[0]);
                end
            end
            if (fifo_rd_en) begin
                pop_cnt++;
                pop_cyc.push_back(cyc);
            end
            if (busy) begin
                log_tx.push_back(tx);
                log_done.push_back(tx_done);
            end
            @(posedge clk);
            #1;
            if (rst) begin
                exp_tx.delete();
                exp_done.delete();
            end else begin
                if (exp_tx.size() > 0) begin
                    void'(exp_tx.pop_front());
                    void'(exp_done.pop_front());
                end
                if (exp_pop && fq.size() > 0) begin
                    b = fq.pop_front();
                    push_frame(b);
                    refresh();
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            tick(1);
            if (exp_tx.size() == 0 && !busy && (!tx_en || fq.size() == 0)) ok = 1'b1;
        end
        if (!ok) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic clear_logs();
        log_tx.delete();
        log_done.delete();
        pop_cyc.delete();
    endtask

    task automatic cfg(input int d, input bit pen, input bit podd, input bit s2);
        baud_div   = 16'(d);
        parity_en  = pen;
        parity_odd = podd;
        stop2      = s2;
    endtask

    // First-cycle level of each bit, gathered from the observed line.
    task automatic check_bits(input string name, input int d, input int nbits,
                              input logic [31:0] exp_vec);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < nbits; k++) begin
            if (k * d < log_tx.size()) v[k] = log_tx[k*d];
        end
        check(name, v, exp_vec);
    endtask

    task automatic check_done_at(input string name, input int idx);
        int ones;
        ones = 0;
        foreach (log_done[i]) if (log_done[i]) ones++;
        check({name, "_done_cnt"}, ones, 1);
        check({name, "_done_pos"}, (idx < log_done.size()) ? log_done[idx] : 1'b0, 1);
    endtask

    initial begin
        int p0;
        int hi;
        bit got;
        rst = 1'b0;
        tx_en = 1'b0;
        cfg(4, 0, 0, 0);
        refresh();
        #1 rst = 1'b1;
        #1;
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_done", tx_done, 0);
        check("reset_rd_en", fifo_rd_en, 0);
        tick(2);
        rst = 1'b0;
        tick(1);

        // 8N1 div=4, 0x55
        clear_logs();
        p0 = pop_cnt;
        cfg(4, 0, 0, 0);
        fq.push_back(8'h55);
        refresh();
        tx_en = 1'b1;
        wait_idle("t1", 200);
        check("t1_pops", pop_cnt - p0, 1);
        check("t1_len", log_tx.size(), 40);
        check_bits("t1_bits", 4, 10, 32'h2AA);
        check_done_at("t1", 39);

        // back-to-back div=2, 0xA5 then 0x3C
        clear_logs();
        p0 = pop_cnt;
        cfg(2, 0, 0, 0);
        fq.push_back(8'hA5);
        fq.push_back(8'h3C);
        refresh();
        wait_idle("t2", 200);
        check("t2_pops", pop_cnt - p0, 2);
        check("t2_len", log_tx.size(), 40);
        check_bits("t2_bits", 2, 20, 32'h9E34A);
        check("t2_spacing", (pop_cyc.size() == 2) ? pop_cyc[1] - pop_cyc[0] : 0, 20);

        // even parity, div=3, 0x07
        clear_logs();
        cfg(3, 1, 0, 0);
        fq.push_back(8'h07);
        refresh();
        wait_idle("t3", 200);
        check("t3_len", log_tx.size(), 33);
        check_bits("t3_bits", 3, 11, 32'h60E);

        // odd parity, same byte
        clear_logs();
        cfg(3, 1, 1, 0);
        fq.push_back(8'h07);
        refresh();
        wait_idle("t3o", 200);
        check("t3o_len", log_tx.size(), 33);
        check_bits("t3o_bits", 3, 11, 32'h40E);

        // two stop bits, div=3, 0xFF
        clear_logs();
        cfg(3, 0, 0, 1);
        fq.push_back(8'hFF);
        refresh();
        wait_idle("t4", 200);
        check("t4_len", log_tx.size(), 33);
        check_bits("t4_bits", 3, 11, 32'h7FE);
        hi = 0;
        for (int i = 27; i < 33 && i < log_tx.size(); i++) if (log_tx[i]) hi++;
        check("t4_stop_high", hi, 6);
        check_done_at("t4", 32);

        // div=0 behaves as div=1
        clear_logs();
        cfg(0, 0, 0, 0);
        fq.push_back(8'h96);
        refresh();
        wait_idle("t5", 100);
        check("t5_len", log_tx.size(), 10);
        check_bits("t5_bits", 1, 10, 32'h32C);

        // disabled transmitter with a non-empty FIFO
        p0 = pop_cnt;
        tx_en = 1'b0;
        cfg(2, 0, 0, 0);
        fq.push_back(8'h12);
        refresh();
        tick(12);
        check("t6_pops", pop_cnt - p0, 0);
        check("t6_tx", tx, 1);
        check("t6_busy", busy, 0);
        fq.delete();
        refresh();
        tick(1);

        // enable dropped mid-frame
        clear_logs();
        p0 = pop_cnt;
        fq.push_back(8'h11);
        fq.push_back(8'h22);
        refresh();
        tx_en = 1'b1;
        tick(6);
        tx_en = 1'b0;
        wait_idle("t7", 200);
        tick(4);
        check("t7_pops", pop_cnt - p0, 1);
        check("t7_len", log_tx.size(), 20);
        check("t7_left", fq.size(), 1);
        fq.delete();
        refresh();
        tick(1);

        // reset during data bit 3
        p0 = pop_cnt;
        cfg(4, 0, 0, 0);
        fq.push_back(8'h55);
        fq.push_back(8'h33);
        refresh();
        tx_en = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            tick(1);
            if (pop_cnt == p0 + 1) got = 1'b1;
        end
        check("t8_first_pop", got, 1);
        tick(16);
        check("t8_pre_tx", tx, 0);
        rst = 1'b1;
        #1;
        check("t8_rst_tx", tx, 1);
        check("t8_rst_busy", busy, 0);
        tick(2);
        check("t8_rst_rd_en", fifo_rd_en, 0);
        rst = 1'b0;
        p0 = pop_cnt;
        tick(1);
        check("t8_repop", pop_cnt - p0, 1);
        wait_idle("t8", 200);
        check("t8_empty", fq.size(), 0);

        tick(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
